// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT full-adder slices per clock, LSB slice first,
// with a carry flip-flop linking slices across edges and a valid/ready handshake on both sides.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int STEPS    = WIDTH / DIG_SAFE;
  localparam int CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIG_SAFE) != 0) begin : g_bad_params
      $error("serial_add_sub: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       a_reg, b_reg, res_reg, sum_reg;
  logic                   carry_reg, cout_reg, overflow_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [DIG_SAFE:0]      c;
  logic [DIG_SAFE-1:0]    s;
  logic [WIDTH+DIG_SAFE-1:0] res_cat;
  logic                   last_step;
  logic                   accept;

  // One DIGIT-wide ripple slice; c[0] comes from the carry flip-flop.
  assign c[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < DIG_SAFE; gi++) begin : g_slice
      assign s[gi]   = a_reg[gi] ^ b_reg[gi] ^ c[gi];
      assign c[gi+1] = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // New slice enters at the top; after STEPS shifts the LSB slice sits at bit 0.
  assign res_cat   = {s, res_reg};
  assign last_step = (cnt_reg == CNT_W'(STEPS - 1));
  assign accept    = in_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      carry_reg    <= 1'b0;
      cnt_reg      <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + ~cin.
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= cin ^ sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> DIG_SAFE;
      b_reg     <= b_reg >> DIG_SAFE;
      carry_reg <= c[DIG_SAFE];
      res_reg   <= res_cat[WIDTH+DIG_SAFE-1:DIG_SAFE];
      cnt_reg   <= cnt_reg + 1'b1;
      if (last_step) begin
        sum_reg      <= res_cat[WIDTH+DIG_SAFE-1:DIG_SAFE];
        cout_reg     <= c[DIG_SAFE];
        overflow_reg <= c[DIG_SAFE] ^ c[DIG_SAFE-1];
      end
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: default 8-bit bit-serial instance and a
// 16-bit, 4-bit-digit instance, with hand-computed expected results.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, ov8, or8 = 0, cin8 = 0, sub8 = 0, co8, of8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        iv16 = 0, ir16, ov16, or16 = 0, cin16 = 0, sub16 = 0, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .overflow(of8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .overflow(of16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic get_ir(input bit big);
    return big ? ir16 : ir8;
  endfunction
  function automatic logic get_ov(input bit big);
    return big ? ov16 : ov8;
  endfunction

  // One full operation: accept, count RUN edges, check result, optional
  // backpressure for 'hold' cycles, then handshake back to IDLE.
  task automatic run_op(input string tag, input bit big, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] esum,
                        input logic ecout, input logic eovf, input int hold, input bit early_ready);
    int lat;
    bit ir_seen;
    logic [15:0] sum_now;
    lat = 0;
    ir_seen = 0;
    if (big) begin a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1; or16 = early_ready; end
    else     begin a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; iv8 = 1; or8 = early_ready; end
    check({tag, " in_ready before accept"}, 32'(get_ir(big)), 32'd1);
    @(posedge clk); #1;
    // Change operands after accept: must not affect the captured operation.
    if (big) begin iv16 = 0; a16 = ~a; b16 = ~b; cin16 = ~cin; sub16 = ~sub; end
    else     begin iv8 = 0; a8 = ~a[7:0]; b8 = ~b[7:0]; cin8 = ~cin; sub8 = ~sub; end
    while (!get_ov(big) && lat < 40) begin
      if (get_ir(big)) ir_seen = 1;
      if (lat == 1) begin if (big) iv16 = 1; else iv8 = 1; end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), big ? 32'd4 : 32'd8);
    check({tag, " in_ready low in RUN"}, 32'(ir_seen), 32'd0);
    sum_now = big ? s16 : {8'h00, s8};
    check({tag, " sum"}, 32'(sum_now), 32'(esum));
    check({tag, " cout"}, 32'(big ? co16 : co8), 32'(ecout));
    check({tag, " overflow"}, 32'(big ? of16 : of8), 32'(eovf));
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, " held out_valid"}, 32'(get_ov(big)), 32'd1);
        check({tag, " held sum"}, 32'(big ? s16 : {8'h00, s8}), 32'(esum));
        check({tag, " in_ready low in DONE"}, 32'(get_ir(big)), 32'd0);
      end
    end
    if (big) begin iv16 = 0; or16 = 1; end else begin iv8 = 0; or8 = 1; end
    @(posedge clk); #1;
    if (big) or16 = 0; else or8 = 0;
    check({tag, " out_valid after handshake"}, 32'(get_ov(big)), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(get_ir(big)), 32'd1);
    check({tag, " sum retained"}, 32'(big ? s16 : {8'h00, s8}), 32'(esum));
  endtask

  initial begin
    int seen;
    #12;
    check("reset in_ready", 32'(ir8), 32'd1);
    check("reset out_valid", 32'(ov8), 32'd0);
    check("reset sum", 32'(s8), 32'd0);
    check("reset cout", 32'(co8), 32'd0);
    check("reset overflow", 32'(of8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("ff+01",      0, 16'h00FF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 0);
    run_op("7f+01",      0, 16'h007F, 16'h0001, 0, 0, 16'h0080, 0, 1, 0, 0);
    run_op("80-01",      0, 16'h0080, 16'h0001, 0, 1, 16'h007F, 1, 1, 0, 1);
    run_op("05-07-1",    0, 16'h0005, 16'h0007, 1, 1, 16'h00FD, 0, 0, 5, 0);
    run_op("3c+c3+1",    0, 16'h003C, 16'h00C3, 1, 0, 16'h0000, 1, 0, 0, 0);
    run_op("w16 ffff+1", 1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 0);
    run_op("w16 8000-1", 1, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0, 0);

    // Abort mid-RUN: reset asserted around the 4th RUN edge.
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; sub8 = 0; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(ov8), 32'd0);
    check("abort sum", 32'(s8), 32'd0);
    check("abort cout", 32'(co8), 32'd0);
    check("abort overflow", 32'(of8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1;
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    check("abort in_ready", 32'(ir8), 32'd1);
    run_op("after reset 12+34", 0, 16'h0012, 16'h0034, 0, 0, 16'h0046, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per clock (full-adder slices per cycle).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B-cin.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL fail elaboration when WIDTH mod DIGIT != 0, or DIGIT < 1.
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL drive in_ready = 1 only in IDLE; accept occurs on an edge with in_valid & in_ready.
REQ-019 SHALL capture a, b, cin, sub into internal registers at accept; later input changes have no effect on that operation.
REQ-020 SHALL, in subtract mode, use ~b as B operand and ~cin as initial carry; add mode uses b and cin.
REQ-021 SHALL in RUN process one DIGIT-bit slice per edge, LSB slice first, via rippled full-adder slices, storing the slice carry in a carry flip-flop between edges.
REQ-022 SHALL spend exactly WIDTH/DIGIT edges in RUN; out_valid rises after the WIDTH/DIGIT-th edge following accept (8 edges for defaults).
REQ-023 SHALL set overflow = (carry into MSB) XOR (carry out of MSB) of the final slice; cout = carry out of MSB.
REQ-024 SHALL update sum, cout, overflow only on the RUN->DONE edge; they hold value until the next RUN->DONE edge.
REQ-025 SHALL hold out_valid = 1 in DONE until an edge with out_ready = 1, then go to IDLE and clear out_valid.
REQ-026 SHALL ignore in_valid in RUN and DONE (no queuing); next accept earliest one edge after result handshake.
REQ-027 SHALL allow out_ready asserted before DONE; it has no effect outside DONE.
REQ-028 SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-029 SHALL, on rst_n low, immediately (asynchronously) enter IDLE, abort any operation, and drive in_ready = 1 after reset released, out_valid = 0, sum = 0, cout = 0, overflow = 0, carry flip-flop = 0.
REQ-030 SHALL produce no out_valid for an operation aborted by reset mid-RUN or mid-DONE.

Verification
REQ-031 Defaults: a=8'hFF, b=8'h01, cin=0, sub=0 -> out_valid 8 edges after accept, sum=8'h00, cout=1, overflow=0.
REQ-032 a=8'h7F, b=8'h01, cin=0, sub=0 -> sum=8'h80, cout=0, overflow=1; a=8'h80, b=8'h01, sub=1, cin=0 -> sum=8'h7F, cout=1, overflow=1.
REQ-033 a=8'h05, b=8'h07, sub=1, cin=1 -> sum=8'hFD, cout=0, overflow=0; in_ready low throughout RUN/DONE, in_valid pulses there ignored.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and sum stable for all 5; handshake returns to IDLE, in_ready=1 next cycle.
REQ-035 rst_n pulsed low on 4th RUN edge -> out_valid never asserts, outputs 0, new operation accepted after release completes normally.
REQ-036 WIDTH=16, DIGIT=4: a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> out_valid 4 edges after accept, sum=16'h0000, cout=1, overflow=0.
